mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter RAM_AW, default 10, meaning data-RAM byte-address width (1024 bytes).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  core presents a memory instruction.
REQ-005 req_ready  out  1  controller accepts a request this cycle.
REQ-006 req_inst  in  32  full instruction word; opcode [6:0], funct3 [14:12].
REQ-007 req_addr  in  64  effective byte address.
REQ-008 req_wdata  in  64  store data, right-justified.
REQ-009 ram_we  out  1  RAM write enable.
REQ-010 ram_inst  out  32  instruction word forwarded to the RAM, which decodes funct3 itself.
REQ-011 ram_address  out  RAM_AW  RAM byte address.
REQ-012 ram_write_data  out  64  RAM write data.
REQ-013 ram_read_data  in  64  RAM registered read data, valid one cycle after the address/inst are presented.
REQ-014 resp_valid  out  1  response available.
REQ-015 resp_ready  in  1  core consumes the response.
REQ-016 resp_rdata  out  64  load result, already extended by the RAM; 0 for stores and faults.
REQ-017 resp_illegal / resp_misaligned / resp_fault  out  1 each  exception flags, at most one set.

Function
REQ-018 FSM states are IDLE, ISSUE, CAPTURE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE with rst low; accept = req_valid & req_ready, latching inst, addr and wdata.
REQ-020 Decode: opcode 0000011 is a load with legal funct3 000–110; opcode 0100011 is a store with legal funct3 000–011; anything else sets resp_illegal.
REQ-021 Alignment: h/hu needs addr[0]=0, w/wu needs addr[1:0]=0, d needs addr[2:0]=0, otherwise resp_misaligned.
REQ-022 Range: any addr[63:RAM_AW] nonzero sets resp_fault; aligned accesses never cross the top of the RAM.
REQ-023 Flag priority SHALL be illegal > misaligned > fault.
REQ-024 A faulted request goes IDLE->RESP with no RAM access: ram_we stays 0 and resp_rdata=0.
REQ-025 Store: IDLE->ISSUE->RESP; ram_we=1 only during ISSUE.
REQ-026 Load: IDLE->ISSUE->CAPTURE->RESP; resp_rdata is captured from ram_read_data at the end of CAPTURE.
REQ-027 Latency from the accept edge to resp_valid SHALL be 1 cycle (fault), 2 cycles (store) or 3 cycles (load).
REQ-028 In ISSUE and CAPTURE, ram_inst, ram_address and ram_write_data SHALL hold the latched values.
REQ-029 In IDLE and RESP, ram_inst=0, ram_address=0 and ram_write_data=0.
REQ-030 RESP holds resp_valid and all response fields stable until resp_ready=1, then goes to IDLE.
REQ-031 No request is accepted in the RESP->IDLE transition cycle.
REQ-032 ram_we SHALL be gated by !rst, so a store in ISSUE while rst is high writes nothing.

Reset
REQ-033 While rst=1 at a posedge: state->IDLE; resp_valid, all flags, resp_rdata and latched request registers->0.
REQ-034 req_ready and ram_we SHALL be 0 during any cycle rst=1.
REQ-035 Reset mid-operation abandons the request with no response.

Structure
REQ-036 A shared package SHALL hold the LOAD/STORE opcode constants, funct3 codes, the FSM state enum and RAM_AW.
REQ-037 A combinational sub-module mem_req_check SHALL take inst and addr and produce the is_load, is_store and three exception flags; the FSM instantiates it once.

Verification
REQ-038 sd 0x1122334455667788 @0x010, then ld @0x010 -> ld resp_rdata=0x1122334455667788 exactly 3 cycles after its accept.
REQ-039 sb 0x80 @0x005, then lb @0x005 -> 0xFFFFFFFFFFFFFF80, lbu @0x005 -> 0x80.
REQ-040 lw @0x006 -> resp_misaligned=1 at accept+1, ram_we never 1; sw @0x400 -> resp_fault=1.
REQ-041 Opcode 0110011 with addr 0x003 -> only resp_illegal=1 (priority check).
REQ-042 resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-043 rst pulsed during ISSUE of sd @0x020 -> no write (later ld @0x020 returns the prior contents), state IDLE, no response.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants, state encoding and decode helpers for the data-memory access controller.
// Everything that the checker, the FSM and the bench must agree on lives here.
package mem_access_ctrl_pkg;

    localparam int RAM_AW = 10;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // Low address bits that must be zero for a naturally aligned access of this width.
    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        case (funct3)
            F3_H, F3_HU: return 3'b001;
            F3_W, F3_WU: return 3'b011;
            F3_D:        return 3'b111;
            default:     return 3'b000;
        endcase
    endfunction

    function automatic logic load_f3_legal(input logic [2:0] funct3);
        return funct3 != 3'b111;
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] funct3);
        return funct3[2] == 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response channel of the memory access controller.
// The core is the master; the controller is the slave.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_inst;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_illegal;
    logic        resp_misaligned;
    logic        resp_fault;

    modport master (
        output req_valid,
        output req_inst,
        output req_addr,
        output req_wdata,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_illegal,
        input  resp_misaligned,
        input  resp_fault
    );

    modport slave (
        input  req_valid,
        input  req_inst,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_illegal,
        output resp_misaligned,
        output resp_fault
    );

endinterface

// File: rtl/mem_access_ctrl_req_check.sv
// Combinational decode of a memory instruction: load/store class plus the exception flags.
// Flags are mutually exclusive with priority illegal > misaligned > fault.
module mem_req_check
    import mem_access_ctrl_pkg::*;
#(
    parameter int AW = RAM_AW
) (
    input  logic [31:0] inst,
    input  logic [63:0] addr,
    output logic        is_load,
    output logic        is_store,
    output logic        illegal,
    output logic        misaligned,
    output logic        fault
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       legal;
    logic       bad_align;
    logic       out_of_range;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        is_load  = (opcode == OPC_LOAD)  && load_f3_legal(funct3);
        is_store = (opcode == OPC_STORE) && store_f3_legal(funct3);
        legal    = is_load || is_store;
    end

    // Aligned accesses cannot straddle the top of the RAM, so only the high bits matter.
    assign bad_align    = |(addr[2:0] & align_mask(funct3));
    assign out_of_range = |addr[63:AW];

    assign illegal    = !legal;
    assign misaligned = legal && bad_align;
    assign fault      = legal && !bad_align && out_of_range;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one load or store at a time between the core channel and a registered-read data RAM.
// Faulting requests skip the RAM and respond on the cycle after acceptance.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int RAM_AW = mem_access_ctrl_pkg::RAM_AW
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus,
    output logic              ram_we,
    output logic [31:0]       ram_inst,
    output logic [RAM_AW-1:0] ram_address,
    output logic [63:0]       ram_write_data,
    input  logic [63:0]       ram_read_data
);

    state_e state;
    logic   ready_q;
    logic   we_q;
    logic   accept;

    logic chk_load;
    logic chk_store;
    logic chk_illegal;
    logic chk_misaligned;
    logic chk_fault;

    mem_req_check #(
        .AW (RAM_AW)
    ) u_req_check (
        .inst       (bus.req_inst),
        .addr       (bus.req_addr),
        .is_load    (chk_load),
        .is_store   (chk_store),
        .illegal    (chk_illegal),
        .misaligned (chk_misaligned),
        .fault      (chk_fault)
    );

    // Reset must block acceptance and writes in the very cycle it is asserted.
    assign bus.req_ready = ready_q & ~rst;
    assign ram_we        = we_q & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            ready_q             <= 1'b1;
            we_q                <= 1'b0;
            ram_inst            <= '0;
            ram_address         <= '0;
            ram_write_data      <= '0;
            bus.resp_valid      <= 1'b0;
            bus.resp_rdata      <= '0;
            bus.resp_illegal    <= 1'b0;
            bus.resp_misaligned <= 1'b0;
            bus.resp_fault      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (chk_illegal || chk_misaligned || chk_fault) begin
                            state               <= ST_RESP;
                            bus.resp_valid      <= 1'b1;
                            bus.resp_rdata      <= '0;
                            bus.resp_illegal    <= chk_illegal;
                            bus.resp_misaligned <= chk_misaligned;
                            bus.resp_fault      <= chk_fault;
                        end else begin
                            state          <= ST_ISSUE;
                            we_q           <= chk_store;
                            ram_inst       <= bus.req_inst;
                            ram_address    <= bus.req_addr[RAM_AW-1:0];
                            ram_write_data <= bus.req_wdata;
                        end
                    end
                end

                ST_ISSUE: begin
                    we_q <= 1'b0;
                    if (we_q) begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= '0;
                        ram_inst       <= '0;
                        ram_address    <= '0;
                        ram_write_data <= '0;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    state          <= ST_RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= ram_read_data;
                    ram_inst       <= '0;
                    ram_address    <= '0;
                    ram_write_data <= '0;
                end

                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state               <= ST_IDLE;
                        ready_q             <= 1'b1;
                        bus.resp_valid      <= 1'b0;
                        bus.resp_rdata      <= '0;
                        bus.resp_illegal    <= 1'b0;
                        bus.resp_misaligned <= 1'b0;
                        bus.resp_fault      <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-addressed registered-read RAM model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_we;
    logic [31:0] ram_inst;
    logic [9:0]  ram_address;
    logic [63:0] ram_write_data;
    logic [63:0] ram_read_data;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.RAM_AW(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .ram_we         (ram_we),
        .ram_inst       (ram_inst),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    function automatic logic [63:0] ram_load(input logic [9:0] a, input logic [2:0] f3);
        logic [63:0] raw;
        raw = '0;
        for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[(int'(a) + i) % 1024];
        case (f3)
            3'b000:  return {{56{raw[7]}}, raw[7:0]};
            3'b001:  return {{48{raw[15]}}, raw[15:0]};
            3'b010:  return {{32{raw[31]}}, raw[31:0]};
            3'b100:  return {56'd0, raw[7:0]};
            3'b101:  return {48'd0, raw[15:0]};
            3'b110:  return {32'd0, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt <= we_cnt + 1;
            for (int i = 0; i < (1 << ram_inst[13:12]); i++)
                mem[(int'(ram_address) + i) % 1024] <= ram_write_data[8*i +: 8];
        end
        ram_read_data <= ram_load(ram_address, ram_inst[14:12]);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] rdata;
        logic        ill;
        logic        mis;
        logic        flt;
        int          n_we;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    function automatic vec_t mkv(input string name, input logic [31:0] inst, input logic [63:0] addr,
                                 input logic [63:0] wdata, input int lat, input logic [63:0] rdata,
                                 input logic ill, input logic mis, input logic flt, input int n_we);
        vec_t v;
        v.name = name; v.inst = inst; v.addr = addr; v.wdata = wdata; v.lat = lat;
        v.rdata = rdata; v.ill = ill; v.mis = mis; v.flt = flt; v.n_we = n_we;
        return v;
    endfunction

    task automatic chk(input string name, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int n;
        int lat;
        int we0;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(v.name, "req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_inst  = v.inst;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        we0 = we_cnt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_inst  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk(v.name, "latency", 64'(lat), 64'(v.lat));
        chk(v.name, "rdata", bus.resp_rdata, v.rdata);
        chk(v.name, "illegal", bus.resp_illegal, v.ill);
        chk(v.name, "misaligned", bus.resp_misaligned, v.mis);
        chk(v.name, "fault", bus.resp_fault, v.flt);
        chk(v.name, "ram writes", 64'(we_cnt - we0), 64'(v.n_we));
        chk(v.name, "ram_address idle", 64'(ram_address), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(v.name, "hold valid", bus.resp_valid, 1);
            chk(v.name, "hold rdata", bus.resp_rdata, v.rdata);
            chk(v.name, "hold req_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        #1;
        chk(v.name, "req_ready at release", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk(v.name, "valid after consume", bus.resp_valid, 0);
        chk(v.name, "req_ready after consume", bus.req_ready, 1);
    endtask

    initial begin
        int n_valid;
        int we0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_inst   = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", "req_ready", bus.req_ready, 0);
        chk("reset", "ram_we", ram_we, 0);
        chk("reset", "resp_valid", bus.resp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post reset", "req_ready", bus.req_ready, 1);
        chk("post reset", "ram_inst", ram_inst, 0);

        vecs.push_back(mkv("sd 0x10",   mk(ST, 3'd3), 64'h010, 64'h1122334455667788, 2, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mkv("ld 0x10",   mk(LD, 3'd3), 64'h010, 64'h0, 3, 64'h1122334455667788, 0, 0, 0, 0));
        vecs.push_back(mkv("sb 0x5",    mk(ST, 3'd0), 64'h005, 64'h80, 2, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mkv("lb 0x5",    mk(LD, 3'd0), 64'h005, 64'h0, 3, 64'hFFFFFFFFFFFFFF80, 0, 0, 0, 0));
        vecs.push_back(mkv("lbu 0x5",   mk(LD, 3'd4), 64'h005, 64'h0, 3, 64'h80, 0, 0, 0, 0));
        vecs.push_back(mkv("lw 0x6",    mk(LD, 3'd2), 64'h006, 64'h0, 1, 64'h0, 0, 1, 0, 0));
        vecs.push_back(mkv("sw 0x400",  mk(ST, 3'd2), 64'h400, 64'h1234, 1, 64'h0, 0, 0, 1, 0));
        vecs.push_back(mkv("op 0x33",   mk(7'b0110011, 3'd0), 64'h003, 64'h0, 1, 64'h0, 1, 0, 0, 0));
        vecs.push_back(mkv("lh 0x10",   mk(LD, 3'd1), 64'h010, 64'h0, 3, 64'h7788, 0, 0, 0, 0));
        vecs.push_back(mkv("lwu 0x14",  mk(LD, 3'd6), 64'h014, 64'h0, 3, 64'h11223344, 0, 0, 0, 0));
        vecs.push_back(mkv("sh 0x22",   mk(ST, 3'd1), 64'h022, 64'hFFFF_FFFF_0000_ABCD, 2, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mkv("lh 0x22",   mk(LD, 3'd1), 64'h022, 64'h0, 3, 64'hFFFFFFFFFFFFABCD, 0, 0, 0, 0));
        vecs.push_back(mkv("lhu 0x22",  mk(LD, 3'd5), 64'h022, 64'h0, 3, 64'hABCD, 0, 0, 0, 0));
        vecs.push_back(mkv("lw 0x20",   mk(LD, 3'd2), 64'h020, 64'h0, 3, 64'hFFFFFFFFABCD0000, 0, 0, 0, 0));
        vecs.push_back(mkv("ld f3=7",   mk(LD, 3'd7), 64'h010, 64'h0, 1, 64'h0, 1, 0, 0, 0));
        vecs.push_back(mkv("st f3=4",   mk(ST, 3'd4), 64'h010, 64'h55, 1, 64'h0, 1, 0, 0, 0));
        vecs.push_back(mkv("ld 0x3F8",  mk(LD, 3'd3), 64'h3F8, 64'h0, 3, 64'h0, 0, 0, 0, 0));
        vecs.push_back(mkv("sd 0x3F8",  mk(ST, 3'd3), 64'h3F8, 64'hCAFEBABE00000001, 2, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mkv("ld 0x3F8b", mk(LD, 3'd3), 64'h3F8, 64'h0, 3, 64'hCAFEBABE00000001, 0, 0, 0, 0));
        vecs.push_back(mkv("sb 0x3FF",  mk(ST, 3'd0), 64'h3FF, 64'h5A, 2, 64'h0, 0, 0, 0, 1));
        vecs.push_back(mkv("lbu 0x3FF", mk(LD, 3'd4), 64'h3FF, 64'h0, 3, 64'h5A, 0, 0, 0, 0));
        vecs.push_back(mkv("ld 0x3FC",  mk(LD, 3'd3), 64'h3FC, 64'h0, 1, 64'h0, 0, 1, 0, 0));
        vecs.push_back(mkv("lb hi bit", mk(LD, 3'd0), 64'h8000000000000000, 64'h0, 1, 64'h0, 0, 0, 1, 0));
        vecs.push_back(mkv("lhu 0x401", mk(LD, 3'd5), 64'h401, 64'h0, 1, 64'h0, 0, 1, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i], 0);

        run_vec(mkv("ld stall", mk(LD, 3'd3), 64'h010, 64'h0, 3, 64'h1122334455667788, 0, 0, 0, 0), 5);

        // Reset pulsed while a store sits in ISSUE: the write must be dropped.
        run_vec(mkv("sd 0x20", mk(ST, 3'd3), 64'h020, 64'h0123456789ABCDEF, 2, 64'h0, 0, 0, 0, 1), 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_inst  = mk(ST, 3'd3);
        bus.req_addr  = 64'h020;
        bus.req_wdata = 64'hFFFFFFFFFFFFFFFF;
        we0 = we_cnt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rst issue", "ram_we before rst", ram_we, 1);
        rst = 1'b1;
        #1;
        chk("rst issue", "ram_we gated", ram_we, 0);
        chk("rst issue", "req_ready gated", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) n_valid++;
        end
        chk("rst issue", "responses", 64'(n_valid), 64'd0);
        chk("rst issue", "ram writes", 64'(we_cnt - we0), 64'd0);
        chk("rst issue", "req_ready idle", bus.req_ready, 1);
        chk("rst issue", "ram_address idle", 64'(ram_address), 64'd0);
        run_vec(mkv("ld 0x20", mk(LD, 3'd3), 64'h020, 64'h0, 3, 64'h0123456789ABCDEF, 0, 0, 0, 0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
